// File: rtl/addr_decoder_multi.sv
// Multi-region data-memory address decoder with one-cycle read return,
// per-region write protect and fault capture with a saturating counter.
module addr_decoder_multi #(
    parameter int                        NUM_REGIONS = 2,
    parameter logic [NUM_REGIONS*32-1:0] REGION_BASE =
        {32'h0000_1000, 32'h0000_0200},
    parameter logic [NUM_REGIONS*8-1:0]  REGION_LOG2 = {8'd12, 8'd8},
    parameter logic [NUM_REGIONS-1:0]    RO_MASK     = '0,
    parameter int                        CNT_W       = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [31:0]                 addr,
    input  logic                        WE,
    input  logic                        RE,
    output logic [NUM_REGIONS-1:0]      CS,
    output logic                        iWE,
    output logic [31:0]                 iAddress,
    input  logic [NUM_REGIONS*32-1:0]   rdata_in,
    output logic [31:0]                 rdata,
    output logic                        rvalid,
    output logic                        fault,
    output logic [31:0]                 fault_addr,
    output logic [CNT_W-1:0]            fault_count
);

    localparam int IDX_W = (NUM_REGIONS > 1) ? $clog2(NUM_REGIONS) : 1;

    logic [NUM_REGIONS-1:0] hit_vec;
    logic [31:0]            keep [NUM_REGIONS];

    for (genvar g = 0; g < NUM_REGIONS; g++) begin : g_region
        localparam logic [7:0]  LG   = REGION_LOG2[8*g +: 8];
        localparam logic [31:0] MSK  = 32'hFFFF_FFFF << LG;
        localparam logic [31:0] BASE = REGION_BASE[32*g +: 32];

        assign hit_vec[g] = (addr & MSK) == (BASE & MSK);
        assign keep[g]    = ~MSK;
    end

    logic             hit;
    logic             ro;
    logic [IDX_W-1:0] win;
    logic [31:0]      loc;
    logic [NUM_REGIONS-1:0] cs_oh;

    // Walk from the top index down so the lowest-index hit overrides.
    always_comb begin
        hit   = 1'b0;
        ro    = 1'b0;
        win   = '0;
        loc   = 32'h0;
        cs_oh = '0;
        for (int i = NUM_REGIONS - 1; i >= 0; i--) begin
            if (hit_vec[i]) begin
                hit       = 1'b1;
                ro        = RO_MASK[i];
                win       = IDX_W'(i);
                loc       = addr & keep[i];
                cs_oh     = '0;
                cs_oh[i]  = 1'b1;
            end
        end
    end

    assign CS       = cs_oh;
    assign iAddress = loc;
    assign iWE      = WE & hit & ~ro;

    logic fault_cond;
    logic rd_acc;

    assign fault_cond = ((RE | WE) & ~hit) | (WE & hit & ro);
    assign rd_acc     = RE & hit;

    logic             rvalid_q, rvalid_d;
    logic [IDX_W-1:0] sel_q, sel_d;
    logic             fault_q, fault_d;
    logic [31:0]      faddr_q, faddr_d;
    logic [CNT_W-1:0] fcnt_q, fcnt_d;

    always_comb begin
        rvalid_d = rd_acc;
        sel_d    = rd_acc ? win : sel_q;
        fault_d  = fault_cond;
        faddr_d  = faddr_q;
        fcnt_d   = fcnt_q;
        if (fault_cond) begin
            faddr_d = addr;
            if (!(&fcnt_q)) begin
                fcnt_d = fcnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rvalid_q <= 1'b0;
            sel_q    <= '0;
            fault_q  <= 1'b0;
            faddr_q  <= 32'h0;
            fcnt_q   <= '0;
        end else begin
            rvalid_q <= rvalid_d;
            sel_q    <= sel_d;
            fault_q  <= fault_d;
            faddr_q  <= faddr_d;
            fcnt_q   <= fcnt_d;
        end
    end

    logic [31:0] rmux;

    always_comb begin
        rmux = 32'h0;
        for (int i = 0; i < NUM_REGIONS; i++) begin
            if (sel_q == IDX_W'(i)) begin
                rmux = rdata_in[32*i +: 32];
            end
        end
    end

    assign rvalid      = rvalid_q;
    assign rdata       = rvalid_q ? rmux : 32'h0;
    assign fault       = fault_q;
    assign fault_addr  = faddr_q;
    assign fault_count = fcnt_q;

endmodule

// File: tb/tb_addr_decoder_multi.sv
// Directed bench for addr_decoder_multi: default map plus a
// second instance with region 1 write-protected.
module tb_addr_decoder_multi;

    logic        clk;
    logic        rst;
    int          checks;
    int          errors;

    logic [31:0] addr_a;
    logic        we_a, re_a;
    logic [1:0]  cs_a;
    logic        iwe_a;
    logic [31:0] iaddr_a;
    logic [63:0] rdin_a;
    logic [31:0] rdata_a;
    logic        rvalid_a, fault_a;
    logic [31:0] faddr_a;
    logic [7:0]  fcnt_a;

    logic [31:0] addr_b;
    logic        we_b, re_b;
    logic [1:0]  cs_b;
    logic        iwe_b;
    logic [31:0] iaddr_b;
    logic [63:0] rdin_b;
    logic [31:0] rdata_b;
    logic        rvalid_b, fault_b;
    logic [31:0] faddr_b;
    logic [7:0]  fcnt_b;

    addr_decoder_multi u_dut (
        .clk(clk), .rst(rst), .addr(addr_a), .WE(we_a), .RE(re_a),
        .CS(cs_a), .iWE(iwe_a), .iAddress(iaddr_a), .rdata_in(rdin_a),
        .rdata(rdata_a), .rvalid(rvalid_a), .fault(fault_a),
        .fault_addr(faddr_a), .fault_count(fcnt_a)
    );

    addr_decoder_multi #(.RO_MASK(2'b10)) u_ro (
        .clk(clk), .rst(rst), .addr(addr_b), .WE(we_b), .RE(re_b),
        .CS(cs_b), .iWE(iwe_b), .iAddress(iaddr_b), .rdata_in(rdin_b),
        .rdata(rdata_b), .rvalid(rvalid_b), .fault(fault_b),
        .fault_addr(faddr_b), .fault_count(fcnt_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (rvalid_a !== 1'b0 || rdata_a !== 32'h0) begin
            errors++;
            $display("FAIL reset_read: rvalid=%b rdata=%h want 0/0",
                     rvalid_a, rdata_a);
        end
        checks++;
        if (fault_a !== 1'b0 || faddr_a !== 32'h0 || fcnt_a !== 8'h0) begin
            errors++;
            $display("FAIL reset_fault: f=%b fa=%h fc=%h want 0/0/0",
                     fault_a, faddr_a, fcnt_a);
        end
    endtask

    task automatic test_write_decode();
        addr_a = 32'h205; we_a = 1'b1;
        #1;
        checks++;
        if (cs_a !== 2'b01 || iaddr_a !== 32'h05 || iwe_a !== 1'b1) begin
            errors++;
            $display("FAIL wr_decode: cs=%b ia=%h iwe=%b want 01/05/1",
                     cs_a, iaddr_a, iwe_a);
        end
        we_a = 1'b0;
        #1;
        checks++;
        if (iwe_a !== 1'b0 || cs_a !== 2'b01) begin
            errors++;
            $display("FAIL wr_off: iwe=%b cs=%b want 0/01", iwe_a, cs_a);
        end
        we_a = 1'b1;
        @(negedge clk);
        we_a = 1'b0;
        checks++;
        if (fault_a !== 1'b0 || fcnt_a !== 8'h0) begin
            errors++;
            $display("FAIL wr_nofault: f=%b fc=%h want 0/00",
                     fault_a, fcnt_a);
        end
    endtask

    task automatic test_boundaries();
        logic [31:0] av [6] = '{32'h2FF, 32'h300, 32'h1FF, 32'h1FFF,
                                32'hFFF, 32'h2000};
        logic [1:0]  ec [6] = '{2'b01, 2'b00, 2'b00, 2'b10,
                                2'b00, 2'b00};
        logic [31:0] ea [6] = '{32'hFF, 32'h0, 32'h0, 32'hFFF,
                                32'h0, 32'h0};
        for (int i = 0; i < 6; i++) begin
            addr_a = av[i];
            #1;
            checks++;
            if (cs_a !== ec[i] || iaddr_a !== ea[i]) begin
                errors++;
                $display("FAIL boundary %h: cs=%b ia=%h want %b/%h",
                         av[i], cs_a, iaddr_a, ec[i], ea[i]);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_read();
        rdin_a = {32'hDEAD_BEEF, 32'h1111_2222};
        addr_a = 32'h1EE2; re_a = 1'b1;
        #1;
        checks++;
        if (cs_a !== 2'b10 || iaddr_a !== 32'hEE2 || iwe_a !== 1'b0) begin
            errors++;
            $display("FAIL rd_decode: cs=%b ia=%h iwe=%b want 10/EE2/0",
                     cs_a, iaddr_a, iwe_a);
        end
        @(negedge clk);
        re_a = 1'b0;
        checks++;
        if (rvalid_a !== 1'b1 || rdata_a !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL rd_data: rv=%b rd=%h want 1/DEADBEEF",
                     rvalid_a, rdata_a);
        end
        @(negedge clk);
        checks++;
        if (rvalid_a !== 1'b0 || rdata_a !== 32'h0) begin
            errors++;
            $display("FAIL rd_drop: rv=%b rd=%h want 0/0",
                     rvalid_a, rdata_a);
        end
    endtask

    task automatic test_back_to_back();
        rdin_a = {32'hB1B1_0001, 32'hA0A0_0000};
        addr_a = 32'h24A; re_a = 1'b1;
        @(negedge clk);
        addr_a = 32'h1249;
        checks++;
        if (rvalid_a !== 1'b1 || rdata_a !== 32'hA0A0_0000) begin
            errors++;
            $display("FAIL b2b_first: rv=%b rd=%h want 1/A0A00000",
                     rvalid_a, rdata_a);
        end
        @(negedge clk);
        re_a = 1'b0;
        checks++;
        if (rvalid_a !== 1'b1 || rdata_a !== 32'hB1B1_0001) begin
            errors++;
            $display("FAIL b2b_second: rv=%b rd=%h want 1/B1B10001",
                     rvalid_a, rdata_a);
        end
        @(negedge clk);
        checks++;
        if (rvalid_a !== 1'b0 || fcnt_a !== 8'h0) begin
            errors++;
            $display("FAIL b2b_end: rv=%b fc=%h want 0/00",
                     rvalid_a, fcnt_a);
        end
    endtask

    task automatic test_fault();
        addr_a = 32'h3000; we_a = 1'b1;
        #1;
        checks++;
        if (cs_a !== 2'b00 || iwe_a !== 1'b0 || iaddr_a !== 32'h0) begin
            errors++;
            $display("FAIL unmap_decode: cs=%b iwe=%b ia=%h want 00/0/0",
                     cs_a, iwe_a, iaddr_a);
        end
        @(negedge clk);
        we_a = 1'b0;
        checks++;
        if (fault_a !== 1'b1 || faddr_a !== 32'h3000 || fcnt_a !== 8'h1) begin
            errors++;
            $display("FAIL unmap_fault: f=%b fa=%h fc=%h want 1/3000/01",
                     fault_a, faddr_a, fcnt_a);
        end
        @(negedge clk);
        checks++;
        if (fault_a !== 1'b0 || fcnt_a !== 8'h1) begin
            errors++;
            $display("FAIL fault_pulse: f=%b fc=%h want 0/01",
                     fault_a, fcnt_a);
        end
    endtask

    task automatic test_saturate();
        addr_a = 32'h8000_0000; re_a = 1'b1;
        repeat (300) @(negedge clk);
        re_a = 1'b0;
        checks++;
        if (rvalid_a !== 1'b0 || fault_a !== 1'b1) begin
            errors++;
            $display("FAIL unmap_read: rv=%b f=%b want 0/1",
                     rvalid_a, fault_a);
        end
        @(negedge clk);
        checks++;
        if (fcnt_a !== 8'hFF || faddr_a !== 32'h8000_0000) begin
            errors++;
            $display("FAIL saturate: fc=%h fa=%h want FF/80000000",
                     fcnt_a, faddr_a);
        end
    endtask

    task automatic test_read_only();
        rdin_b = {32'hC0DE_0001, 32'h0};
        addr_b = 32'h1249; we_b = 1'b1;
        #1;
        checks++;
        if (cs_b !== 2'b10 || iwe_b !== 1'b0) begin
            errors++;
            $display("FAIL ro_decode: cs=%b iwe=%b want 10/0",
                     cs_b, iwe_b);
        end
        @(negedge clk);
        we_b = 1'b0;
        checks++;
        if (fault_b !== 1'b1 || faddr_b !== 32'h1249 || fcnt_b !== 8'h1) begin
            errors++;
            $display("FAIL ro_fault: f=%b fa=%h fc=%h want 1/1249/01",
                     fault_b, faddr_b, fcnt_b);
        end
        addr_b = 32'h1100; we_b = 1'b1; re_b = 1'b1;
        @(negedge clk);
        we_b = 1'b0; re_b = 1'b0;
        checks++;
        if (rvalid_b !== 1'b1 || rdata_b !== 32'hC0DE_0001 ||
            fault_b !== 1'b1 || fcnt_b !== 8'h2) begin
            errors++;
            $display("FAIL ro_rw: rv=%b rd=%h f=%b fc=%h want 1/C0DE0001/1/02",
                     rvalid_b, rdata_b, fault_b, fcnt_b);
        end
        addr_b = 32'h210; we_b = 1'b1;
        #1;
        checks++;
        if (iwe_b !== 1'b1 || cs_b !== 2'b01 || iaddr_b !== 32'h10) begin
            errors++;
            $display("FAIL rw_region: iwe=%b cs=%b ia=%h want 1/01/10",
                     iwe_b, cs_b, iaddr_b);
        end
        @(negedge clk);
        we_b = 1'b0;
        checks++;
        if (fault_b !== 1'b0 || fcnt_b !== 8'h2) begin
            errors++;
            $display("FAIL rw_nofault: f=%b fc=%h want 0/02",
                     fault_b, fcnt_b);
        end
    endtask

    task automatic test_reset_read();
        rdin_a = {32'h0, 32'h5555_AAAA};
        rst = 1'b1; addr_a = 32'h205; re_a = 1'b1;
        #1;
        checks++;
        if (cs_a !== 2'b01 || iaddr_a !== 32'h05) begin
            errors++;
            $display("FAIL rst_comb: cs=%b ia=%h want 01/05",
                     cs_a, iaddr_a);
        end
        @(negedge clk);
        rst = 1'b0; re_a = 1'b0;
        checks++;
        if (rvalid_a !== 1'b0 || rdata_a !== 32'h0 ||
            fcnt_a !== 8'h0 || faddr_a !== 32'h0) begin
            errors++;
            $display("FAIL rst_read: rv=%b rd=%h fc=%h fa=%h want 0/0/0/0",
                     rvalid_a, rdata_a, fcnt_a, faddr_a);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b1;
        addr_a = 32'h0; we_a = 1'b0; re_a = 1'b0; rdin_a = '0;
        addr_b = 32'h0; we_b = 1'b0; re_b = 1'b0; rdin_b = '0;
        test_reset();
        test_write_decode();
        test_boundaries();
        test_read();
        test_back_to_back();
        test_fault();
        test_saturate();
        test_read_only();
        test_reset_read();
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule

// File: doc/addr_decoder_multi.md
Name: addr_decoder_multi

Overview:
- Parametrised successor to the single-region data-memory address decoder.
- Decodes a 32-bit core data address into NUM_REGIONS aligned, power-of-two regions. Produces a one-hot chip select, a region-local address and a gated write enable for each access.
- Adds registered behaviour the old decoder lacks: a one-cycle read-data return mux, write-protect per region, and fault capture with a saturating fault counter.
- Sits between the core load/store unit and the data RAM / peripheral blocks.

Parameters:
- NUM_REGIONS, 2, number of decoded regions (1..8).
- REGION_BASE, {32'h0000_1000, 32'h0000_0200}, packed NUM_REGIONS*32 base addresses. Region i is at bits [32*i+31:32*i].
- REGION_LOG2, {8'd12, 8'd8}, packed NUM_REGIONS*8 region sizes as log2 bytes (2..31).
- RO_MASK, 2'b00, NUM_REGIONS bits; bit i = 1 makes region i read-only.
- CNT_W, 8, fault counter width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- addr  in  32  access address.
- WE  in  1  write request.
- RE  in  1  read request.
- CS  out  NUM_REGIONS  one-hot region select (combinational).
- iWE  out  1  gated write enable to the selected region (combinational).
- iAddress  out  32  region-local offset (combinational).
- rdata_in  in  NUM_REGIONS*32  packed read data from the regions, valid one cycle after RE.
- rdata  out  32  returned read data.
- rvalid  out  1  read data valid.
- fault  out  1  one-cycle fault pulse.
- fault_addr  out  32  address of the most recent fault.
- fault_count  out  CNT_W  saturating count of faults.

Behaviour:
- Hit rule: region i hits when addr[31:L] == REGION_BASE_i[31:L], where L = REGION_LOG2_i.
- Overlapping hits: the lowest index wins, so CS is always one-hot or zero.
- CS: driven by address alone, independent of RE/WE. All zeros when nothing hits.
- iAddress: addr with bits >= L of the winning region cleared. It is 32'h0 when there is no hit.
- iWE = WE & hit & ~RO_MASK[winner]. It is never asserted for unmapped or read-only addresses.
- Read path, 1-cycle latency:
  - On a clock edge with RE & hit, register sel_q = winner and set rvalid = 1 for the next cycle.
  - In that cycle rdata = rdata_in slice sel_q.
  - Otherwise rvalid = 0 and rdata = 32'h0.
  - Back-to-back reads give one rvalid per cycle, each tracking its own sel_q.
- Fault condition: (RE | WE) & ~hit, or WE & hit & RO_MASK[winner]. When it holds at a clock edge:
  - next cycle fault = 1 for exactly one cycle;
  - fault_addr = addr;
  - fault_count increments, saturating at all ones.
- Faults do not block the access's other outputs. An RE to an unmapped address gives a fault and no rvalid.
- RE and WE together on a mapped region: iWE follows the write rule and the read completes normally. If the region is read-only, fault is raised and the read still completes.
- Reset: rvalid=0, rdata=0, fault=0, fault_addr=0, fault_count=0, sel_q=0. A read accepted in the cycle where rst is high is discarded (rvalid stays 0 after reset).
- Combinational outputs are unaffected by rst.

Test Plan:
- Defaults, addr=32'h205, WE=1 → CS=2'b01, iAddress=32'h05, iWE=1, no fault. Same with WE=0 → iWE=0.
- Defaults, addr=32'h1EE2, RE=1, rdata_in slice1=32'hDEAD_BEEF → CS=2'b10, iAddress=32'hEE2. Next cycle rvalid=1, rdata=32'hDEAD_BEEF.
- Defaults, back-to-back RE at 32'h24A then 32'h1249 → consecutive rvalid cycles returning slice0 then slice1 data.
- Defaults, WE=1 at addr=32'h3000 → CS=0, iWE=0. Next cycle fault=1, fault_addr=32'h3000, fault_count=1. After 300 unmapped accesses, fault_count stays at 8'hFF.
- RO_MASK=2'b10, WE=1 at 32'h1249 → CS=2'b10, iWE=0, fault pulse, fault_addr=32'h1249.
- Assert rst for one cycle coincident with RE at 32'h205 → next cycle rvalid=0, fault_count=0, fault_addr=0.
